// File: rtl/dma_rx_pkt_fifo_pkg.sv
// Shared widths, write-side state encoding and pointer sizing for the RX packet FIFO.
package dma_rx_pkt_fifo_pkg;

  localparam int DATA_W  = 512;
  localparam int KEEP_W  = 64;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;

  typedef enum logic {
    W_ACCEPT = 1'b0,
    W_DROP   = 1'b1
  } wr_state_t;

  // One extra MSB beyond the address bits separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_rx_pkt_fifo_ram.sv
// Simple dual-port storage with a registered read port; contents are never reset.
module pkt_fifo_sdp_ram #(
  parameter int W     = 577,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dma_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: packets become visible only once their tlast
// beat is committed; errored or overflowing packets are rewound and counted as drops.
module dma_rx_pkt_fifo
  import dma_rx_pkt_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [CNT_W-1:0]  rx_drop_cnt
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]    PTR_DEPTH = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  wr_state_t            wr_state;
  logic [PW-1:0]        wr_tent;
  logic [PW-1:0]        wr_commit;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        fetch_ptr;
  logic                 full;
  logic                 wr_en;
  logic                 ram_re;
  logic                 s1_valid;
  logic                 out_ready;
  logic                 s1_move;
  logic                 out_fire;
  logic [ENTRY_W-1:0]   ram_rdata;

  // rd_ptr only advances on a downstream handshake, so beats sitting in the
  // read pipeline still occupy FIFO space and full reflects true capacity.
  assign full      = (wr_tent - rd_ptr) == PTR_DEPTH;
  assign wr_en     = s_axis_tvalid && (wr_state == W_ACCEPT) && !full;
  assign out_fire  = m_axis_tvalid && m_axis_tready;
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign s1_move   = s1_valid && out_ready;
  assign ram_re    = (fetch_ptr != wr_commit) && (!s1_valid || out_ready);
  assign m_axis_tuser = 1'b0;

  pkt_fifo_sdp_ram #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (core_clk),
    .we    (wr_en),
    .waddr (wr_tent[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re    (ram_re),
    .raddr (fetch_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      wr_state    <= W_ACCEPT;
      wr_tent     <= '0;
      wr_commit   <= '0;
      rx_pkt_cnt  <= '0;
      rx_drop_cnt <= '0;
    end else if (s_axis_tvalid) begin
      if (wr_state == W_DROP) begin
        if (s_axis_tlast) begin
          wr_state <= W_ACCEPT;
          if (rx_drop_cnt != CNT_MAX) rx_drop_cnt <= rx_drop_cnt + CNT_ONE;
        end
      end else if (full) begin
        wr_tent <= wr_commit;
        if (s_axis_tlast) begin
          if (rx_drop_cnt != CNT_MAX) rx_drop_cnt <= rx_drop_cnt + CNT_ONE;
        end else begin
          wr_state <= W_DROP;
        end
      end else if (s_axis_tlast && s_axis_tuser) begin
        wr_tent <= wr_commit;
        if (rx_drop_cnt != CNT_MAX) rx_drop_cnt <= rx_drop_cnt + CNT_ONE;
      end else begin
        wr_tent <= wr_tent + PTR_ONE;
        if (s_axis_tlast) begin
          wr_commit <= wr_tent + PTR_ONE;
          if (rx_pkt_cnt != CNT_MAX) rx_pkt_cnt <= rx_pkt_cnt + CNT_ONE;
        end
      end
    end
  end

  // Read pipeline: fetch_ptr feeds the RAM, s1_valid tracks the RAM output
  // register, and the m_axis register holds steady while stalled.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      s1_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      if (ram_re) fetch_ptr <= fetch_ptr + PTR_ONE;
      if (ram_re) s1_valid <= 1'b1;
      else if (s1_move) s1_valid <= 1'b0;
      if (s1_move) begin
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_rdata;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (out_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: doc/dma_rx_pkt_fifo.md
DMA_RX_PKT_FIFO -- requirements
Module: dma_rx_pkt_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, FIFO depth in 512-bit beats (power of 2, >=4); CNT_W, default 32, statistics counter width.
REQ-002 Ports SHALL be:
- core_clk  in  1  single clock for all logic
- core_rst  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  512  non-RoCE RX beat from the packet filter's DMA output
- s_axis_tkeep  in  64  byte enables
- s_axis_tlast  in  1  end of packet
- s_axis_tuser  in  1  CMAC error flag, meaningful on the tlast beat
- s_axis_tvalid  in  1  beat valid; there is no s_axis_tready
- m_axis_tdata  out  512  buffered packet data to the DMA
- m_axis_tkeep  out  64  byte enables
- m_axis_tlast  out  1  end of packet
- m_axis_tuser  out  1  always 0
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  DMA ready
- rx_pkt_cnt  out  CNT_W  good packets committed
- rx_drop_cnt  out  CNT_W  packets dropped (error or overflow)

Function
REQ-003 The block SHALL be store-and-forward: no beat of a packet appears on m_axis until that packet's tlast beat is committed.
REQ-004 Storage SHALL be DEPTH entries of {tdata, tkeep, tlast}. tuser is not stored.
REQ-005 The block SHALL keep three pointers of log2(DEPTH)+1 bits: wr_tent, wr_commit and rd_ptr. They wrap modulo 2*DEPTH, with the MSB distinguishing full from empty.
REQ-006 full SHALL be (wr_tent - rd_ptr) == DEPTH, evaluated on registered pointers. A read in the same cycle does not relieve full.
REQ-007 The write side SHALL use a state machine with states W_ACCEPT and W_DROP.
REQ-008 In W_ACCEPT, a valid beat that is not full SHALL be written at wr_tent, and wr_tent increments.
REQ-009 In W_ACCEPT, a valid tlast beat that is not full:
- tuser=0: wr_commit <= wr_tent+1, and rx_pkt_cnt increments.
- tuser=1: wr_tent <= wr_commit, and rx_drop_cnt increments.
REQ-010 In W_ACCEPT, a valid beat arriving while full SHALL set wr_tent <= wr_commit.
- tlast=1: rx_drop_cnt increments and the state stays W_ACCEPT.
- tlast=0: the state goes to W_DROP.
REQ-011 In W_DROP, all beats SHALL be discarded. A valid tlast beat increments rx_drop_cnt and returns the state to W_ACCEPT.
REQ-012 A packet longer than DEPTH beats SHALL be dropped through the overflow path.
REQ-013 The read side SHALL present data only from entries in [rd_ptr, wr_commit). Empty is rd_ptr == wr_commit.
REQ-014 The read side SHALL use a one-cycle synchronous RAM read followed by one output register. The result:
- m_axis_tvalid rises 2 cycles after the commit edge when the FIFO was empty.
- Full throughput of one beat per cycle is sustained while m_axis_tready=1.
REQ-015 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL hold stable. A beat transfers only on tvalid & tready.
REQ-016 Both counters SHALL saturate at all-ones and never wrap.
REQ-017 Write-side rewind and read-side advance in the same cycle SHALL be independent. A rewind never moves rd_ptr or wr_commit.

Reset
REQ-018 Assertion of core_rst=0 SHALL asynchronously clear:
- all pointers and both counters to 0;
- the write state to W_ACCEPT;
- m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep and m_axis_tuser to 0.
REQ-019 Reset mid-packet SHALL discard all stored and partial packets. The first valid beat after release starts a new packet; the upstream filter shares core_rst.
REQ-020 RAM contents SHALL NOT require reset.

Structure
REQ-021 A shared package SHALL hold DATA_W=512, KEEP_W=64, the write-state encoding and a clog2-based pointer-width function.
REQ-022 Storage SHALL be one sub-module, pkt_fifo_sdp_ram: simple dual-port, 577-bit wide, DEPTH deep, registered read.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Good 3-beat packet, m_axis_tready=1 -> m_axis_tvalid 2 cycles after the tlast beat; identical data/keep; tlast on beat 3; rx_pkt_cnt=1.
- 4-beat packet with tuser=1 on tlast -> nothing on m_axis; rx_drop_cnt=1; the next good 2-beat packet is output intact.
- DEPTH=64, m_axis_tready=0, 70-beat packet -> dropped; rx_drop_cnt=1; FIFO empty; a following 2-beat packet is committed and output after tready=1.
- Two back-to-back 32-beat packets, tready=0 (FIFO exactly full), then a third 1-beat packet -> third dropped; after tready=1, 64 beats out in order; rx_pkt_cnt=2.
- Random tready toggling over 100 packets with pointer wrap -> output stream equals the committed input stream with no duplication; m_axis stable during stalls.
- core_rst=0 asserted mid-packet with 10 beats committed -> m_axis_tvalid=0 immediately; counters=0; the next packet is output correctly after release.
